// File: rtl/windowed_register_file_pkg.sv
// ---------------------------------------------------------------------------
// windowed_register_file_pkg
// Shared constants and types for the windowed register file:
//   NGLOBALS         - number of global registers (r0-r7)
//   WINDOW_REGS      - physical registers owned by each window
//   DEFAULT_WIDTH    - default register data width
//   DEFAULT_NWINDOWS - default number of register windows
//   clr_state_t      - states of the window clear engine
//   phys_count()     - total physical register count for a window count
// ---------------------------------------------------------------------------
package windowed_register_file_pkg;

  localparam int NGLOBALS         = 8;
  localparam int WINDOW_REGS      = 16;
  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_NWINDOWS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  // Globals followed by one 16-register slice per window; each window's ins
  // are shared with the next window's outs, so no extra storage is needed.
  function automatic int phys_count(input int nwin);
    return NGLOBALS + WINDOW_REGS * nwin;
  endfunction

endpackage

// File: rtl/windowed_register_file_window_addr_map.sv
// ---------------------------------------------------------------------------
// window_addr_map
// Converts a logical register number and a window pointer into a physical
// register index.
//   laddr - logical register number r0-r31
//   cwp   - window pointer used for the translation
//   pidx  - physical register index
// ---------------------------------------------------------------------------
module window_addr_map
  import windowed_register_file_pkg::*;
#(
  parameter int NWINDOWS = DEFAULT_NWINDOWS,
  parameter int CWPW     = $clog2(NWINDOWS),
  parameter int PIDXW    = $clog2(phys_count(NWINDOWS))
) (
  input  logic [4:0]       laddr,
  input  logic [CWPW-1:0]  cwp,
  output logic [PIDXW-1:0] pidx
);

  localparam int SPAN = WINDOW_REGS * NWINDOWS;

  logic [31:0] offset;

  // Globals map straight through. Windowed registers are offset by 16 per
  // window and wrap around the windowed region. The largest possible sum is
  // 23 + 16*(NWINDOWS-1), which is below 2*SPAN, so a single conditional
  // subtract replaces the modulo and works for non-power-of-two window counts.
  always_comb begin
    offset = '0;
    pidx   = '0;
    if (laddr < 5'(NGLOBALS)) begin
      pidx = PIDXW'(laddr);
    end else begin
      offset = 32'(laddr) - 32'(NGLOBALS) + 32'(WINDOW_REGS) * 32'(cwp);
      if (offset >= 32'(SPAN)) begin
        offset = offset - 32'(SPAN);
      end
      pidx = PIDXW'(32'(NGLOBALS) + offset);
    end
  end

endmodule

// File: rtl/windowed_register_file.sv
// ---------------------------------------------------------------------------
// windowed_register_file
// SPARC-style windowed register file with save/restore window rotation,
// overflow/underflow traps driven by a window invalid mask, and a background
// engine that zeroes the locals and outs of a window.
//   Clk            - rising-edge clock
//   Clr            - asynchronous active-low reset
//   in             - write data
//   PA_in, PB_in   - logical read addresses, ports A and B
//   PC_in          - logical write address, port C
//   enable, rw     - a write happens when both are high (and not busy)
//   save, restore  - window change requests
//   wim            - window invalid mask
//   wclr           - start clearing the current window
//   PA_out, PB_out - combinational read data with write bypass
//   cwp            - current window pointer
//   trap_overflow  - one-cycle pulse when save targets an invalid window
//   trap_underflow - one-cycle pulse when restore targets an invalid window
//   busy           - clear engine is zeroing registers
//   wclr_done      - one-cycle pulse when a clear has finished
// ---------------------------------------------------------------------------
module windowed_register_file
  import windowed_register_file_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NWINDOWS = DEFAULT_NWINDOWS
) (
  input  logic                        Clk,
  input  logic                        Clr,
  input  logic [WIDTH-1:0]            in,
  input  logic [4:0]                  PA_in,
  input  logic [4:0]                  PB_in,
  input  logic [4:0]                  PC_in,
  input  logic                        enable,
  input  logic                        rw,
  input  logic                        save,
  input  logic                        restore,
  input  logic [NWINDOWS-1:0]         wim,
  input  logic                        wclr,
  output logic [WIDTH-1:0]            PA_out,
  output logic [WIDTH-1:0]            PB_out,
  output logic [$clog2(NWINDOWS)-1:0] cwp,
  output logic                        trap_overflow,
  output logic                        trap_underflow,
  output logic                        busy,
  output logic                        wclr_done
);

  localparam int CWPW  = $clog2(NWINDOWS);
  localparam int NPHYS = phys_count(NWINDOWS);
  localparam int PIDXW = $clog2(NPHYS);

  logic [WIDTH-1:0] regs [NPHYS];

  logic [PIDXW-1:0] pidx_a;
  logic [PIDXW-1:0] pidx_b;
  logic [PIDXW-1:0] pidx_c;
  logic [PIDXW-1:0] pidx_clr;

  clr_state_t      clr_state;
  clr_state_t      clr_next;
  logic [3:0]      clr_cnt;
  logic [CWPW-1:0] clr_cwp;
  logic [4:0]      clr_laddr;
  logic            clr_we;

  logic            ext_we;
  logic            save_req;
  logic            restore_req;
  logic [CWPW-1:0] cwp_dec;
  logic [CWPW-1:0] cwp_inc;

  // Address translation for the two read ports, the write port and the clear
  // engine. The clear engine uses its latched window so that it stays on the
  // same window even if something else ever moved cwp.
  window_addr_map #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PIDXW(PIDXW)) u_map_a (
    .laddr(PA_in), .cwp(cwp), .pidx(pidx_a)
  );
  window_addr_map #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PIDXW(PIDXW)) u_map_b (
    .laddr(PB_in), .cwp(cwp), .pidx(pidx_b)
  );
  window_addr_map #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PIDXW(PIDXW)) u_map_c (
    .laddr(PC_in), .cwp(cwp), .pidx(pidx_c)
  );
  window_addr_map #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PIDXW(PIDXW)) u_map_clr (
    .laddr(clr_laddr), .cwp(clr_cwp), .pidx(pidx_clr)
  );

  // Qualify the external requests. Writes to r0 are dropped here so r0 is
  // never stored. Everything external except reads is frozen while the clear
  // engine owns the array, and a simultaneous save+restore is treated as no
  // request at all.
  always_comb begin
    ext_we      = enable & rw & ~busy & (PC_in != 5'd0);
    save_req    = save & ~restore & ~busy;
    restore_req = restore & ~save & ~busy;
    cwp_dec     = (cwp == '0) ? CWPW'(NWINDOWS - 1) : cwp - CWPW'(1);
    cwp_inc     = (cwp == CWPW'(NWINDOWS - 1)) ? '0 : cwp + CWPW'(1);
    clr_laddr   = 5'(NGLOBALS) + {1'b0, clr_cnt};
  end

  // Read ports: array lookup, overridden by the write data when the same
  // physical register is being written this cycle, and forced to zero for r0.
  always_comb begin
    PA_out = regs[pidx_a];
    if (ext_we && (pidx_a == pidx_c)) PA_out = in;
    if (PA_in == 5'd0) PA_out = '0;
    PB_out = regs[pidx_b];
    if (ext_we && (pidx_b == pidx_c)) PB_out = in;
    if (PB_in == 5'd0) PB_out = '0;
  end

  // Register array storage. The clear engine and external writes never
  // collide because external writes are blocked while busy.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      for (int i = 0; i < NPHYS; i++) regs[i] <= '0;
    end else if (clr_we) begin
      regs[pidx_clr] <= '0;
    end else if (ext_we) begin
      regs[pidx_c] <= in;
    end
  end

  // Window pointer and trap pulses. A save/restore that would land on an
  // invalid window leaves cwp alone and raises the matching trap for exactly
  // the next cycle; the traps clear themselves every other cycle.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      cwp            <= '0;
      trap_overflow  <= 1'b0;
      trap_underflow <= 1'b0;
    end else begin
      trap_overflow  <= 1'b0;
      trap_underflow <= 1'b0;
      if (save_req) begin
        if (wim[cwp_dec]) trap_overflow <= 1'b1;
        else              cwp           <= cwp_dec;
      end else if (restore_req) begin
        if (wim[cwp_inc]) trap_underflow <= 1'b1;
        else              cwp            <= cwp_inc;
      end
    end
  end

  // Clear engine state register.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) clr_state <= IDLE;
    else      clr_state <= clr_next;
  end

  // Clear engine next-state logic: a request in IDLE starts a 16-cycle sweep,
  // after which DONE lasts a single cycle before returning to IDLE.
  always_comb begin
    clr_next = clr_state;
    case (clr_state)
      IDLE:    if (wclr) clr_next = CLEAR;
      CLEAR:   if (clr_cnt == 4'd15) clr_next = DONE;
      DONE:    clr_next = IDLE;
      default: clr_next = IDLE;
    endcase
  end

  // Clear engine outputs, decoded purely from the state so that a reset
  // drops them immediately.
  always_comb begin
    busy      = (clr_state == CLEAR);
    wclr_done = (clr_state == DONE);
    clr_we    = (clr_state == CLEAR);
  end

  // Clear engine datapath: capture the window being cleared when the sweep
  // starts and step through its sixteen locals/outs one per cycle.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      clr_cnt <= '0;
      clr_cwp <= '0;
    end else if ((clr_state == IDLE) && wclr) begin
      clr_cnt <= '0;
      clr_cwp <= cwp;
    end else if (clr_state == CLEAR) begin
      clr_cnt <= clr_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_windowed_register_file.sv
// ---------------------------------------------------------------------------
// tb_windowed_register_file
// Self-checking bench for windowed_register_file (WIDTH=32, NWINDOWS=4):
// a vector table for basic read/write/bypass behaviour, hand-written
// sequences for windows, traps, clearing and reset, and a randomized run
// against a behavioural model of the register windows.
// ---------------------------------------------------------------------------
module tb_windowed_register_file;

  localparam int W  = 32;
  localparam int NW = 4;
  localparam int NP = 8 + 16 * NW;

  logic          Clk;
  logic          Clr;
  logic [W-1:0]  in;
  logic [4:0]    PA_in;
  logic [4:0]    PB_in;
  logic [4:0]    PC_in;
  logic          enable;
  logic          rw;
  logic          save;
  logic          restore;
  logic [NW-1:0] wim;
  logic          wclr;
  logic [W-1:0]  PA_out;
  logic [W-1:0]  PB_out;
  logic [1:0]    cwp;
  logic          trap_overflow;
  logic          trap_underflow;
  logic          busy;
  logic          wclr_done;

  windowed_register_file #(.WIDTH(W), .NWINDOWS(NW)) dut (
    .Clk(Clk), .Clr(Clr), .in(in), .PA_in(PA_in), .PB_in(PB_in),
    .PC_in(PC_in), .enable(enable), .rw(rw), .save(save), .restore(restore),
    .wim(wim), .wclr(wclr), .PA_out(PA_out), .PB_out(PB_out), .cwp(cwp),
    .trap_overflow(trap_overflow), .trap_underflow(trap_underflow),
    .busy(busy), .wclr_done(wclr_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: flat physical array plus window pointer.
  logic [31:0] model [NP];
  int          mcwp;
  logic        exp_ov;
  logic        exp_un;

  typedef struct {
    logic        en;
    logic        rwv;
    logic [4:0]  pc;
    logic [31:0] din;
    logic [4:0]  pa;
    logic [4:0]  pb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [10];

  function automatic int phys(input int r, input int c);
    if (r < 8) return r;
    return 8 + ((r - 8) + 16 * c) % (16 * NW);
  endfunction

  task automatic applyStimulus(input logic en_v, input logic rw_v,
                               input logic [4:0] pc, input logic [31:0] d,
                               input logic [4:0] pa, input logic [4:0] pb,
                               input logic sv, input logic rs, input logic wc);
    enable  = en_v;
    rw      = rw_v;
    PC_in   = pc;
    in      = d;
    PA_in   = pa;
    PB_in   = pb;
    save    = sv;
    restore = rs;
    wclr    = wc;
  endtask

  task automatic driveIdle();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic readCheck(input string name, input logic [4:0] r,
                           input logic [31:0] exp);
    @(negedge Clk);
    driveIdle();
    PA_in = r;
    #1;
    checkOutput(name, 64'(PA_out), 64'(exp));
  endtask

  initial begin
    int busy_cycles;
    logic [3:0] wim_r;
    logic en_r, rw_r, sv_r, rs_r;
    logic [4:0] pc_r, pa_r, pb_r;
    logic [31:0] d_r, ea, eb;
    int tgt;

    // Basic write/read/bypass vectors, all at cwp=0 after reset.
    vecs[0] = '{1'b1, 1'b1, 5'd1,  32'd11,        5'd1,  5'd0,  32'd11,        32'd0};
    vecs[1] = '{1'b1, 1'b1, 5'd9,  32'd22,        5'd1,  5'd9,  32'd11,        32'd22};
    vecs[2] = '{1'b1, 1'b1, 5'd0,  32'd9,         5'd0,  5'd1,  32'd0,         32'd11};
    vecs[3] = '{1'b0, 1'b0, 5'd0,  32'd0,         5'd0,  5'd9,  32'd0,         32'd22};
    vecs[4] = '{1'b1, 1'b1, 5'd5,  32'd7,         5'd5,  5'd24, 32'd7,         32'd0};
    vecs[5] = '{1'b1, 1'b1, 5'd31, 32'h0000dead,  5'd31, 5'd5,  32'h0000dead,  32'd7};
    vecs[6] = '{1'b0, 1'b0, 5'd0,  32'd0,         5'd31, 5'd0,  32'h0000dead,  32'd0};
    vecs[7] = '{1'b1, 1'b0, 5'd2,  32'd55,        5'd2,  5'd2,  32'd0,         32'd0};
    vecs[8] = '{1'b0, 1'b1, 5'd3,  32'd66,        5'd3,  5'd1,  32'd0,         32'd11};
    vecs[9] = '{1'b0, 1'b0, 5'd0,  32'd0,         5'd2,  5'd3,  32'd0,         32'd0};

    Clr = 1'b0;
    wim = '0;
    driveIdle();
    PA_in = 5'd1;
    repeat (2) @(negedge Clk);
    #1;
    checkOutput("reset_cwp",      64'(cwp), 64'd0);
    checkOutput("reset_busy",     64'(busy), 64'd0);
    checkOutput("reset_done",     64'(wclr_done), 64'd0);
    checkOutput("reset_trap_ov",  64'(trap_overflow), 64'd0);
    checkOutput("reset_trap_un",  64'(trap_underflow), 64'd0);
    checkOutput("reset_read",     64'(PA_out), 64'd0);
    Clr = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].en, vecs[i].rwv, vecs[i].pc, vecs[i].din,
                    vecs[i].pa, vecs[i].pb, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("vec%0d_a", i), 64'(PA_out), 64'(vecs[i].exp_a));
      checkOutput($sformatf("vec%0d_b", i), 64'(PB_out), 64'(vecs[i].exp_b));
      @(negedge Clk);
    end

    // Save from window 0 lands in window 3, whose ins alias window 0 outs.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge Clk);
    driveIdle();
    #1;
    checkOutput("save_cwp", 64'(cwp), 64'd3);
    readCheck("alias_r1", 5'd1, 32'd11);
    readCheck("alias_r25", 5'd25, 32'd22);

    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge Clk);
    driveIdle();
    #1;
    checkOutput("restore_cwp", 64'(cwp), 64'd0);

    // Overflow trap: window 3 is invalid.
    wim = 4'b1000;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge Clk);
    driveIdle();
    #1;
    checkOutput("ovf_trap_high", 64'(trap_overflow), 64'd1);
    checkOutput("ovf_un_low", 64'(trap_underflow), 64'd0);
    checkOutput("ovf_cwp_hold", 64'(cwp), 64'd0);
    @(negedge Clk);
    #1;
    checkOutput("ovf_trap_pulse", 64'(trap_overflow), 64'd0);

    // Underflow trap: window 1 is invalid.
    wim = 4'b0010;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge Clk);
    driveIdle();
    #1;
    checkOutput("unf_trap_high", 64'(trap_underflow), 64'd1);
    checkOutput("unf_cwp_hold", 64'(cwp), 64'd0);
    @(negedge Clk);
    #1;
    checkOutput("unf_trap_pulse", 64'(trap_underflow), 64'd0);

    // Save and restore together do nothing, even with every window invalid.
    wim = 4'b1111;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    @(negedge Clk);
    driveIdle();
    #1;
    checkOutput("both_cwp", 64'(cwp), 64'd0);
    checkOutput("both_ov", 64'(trap_overflow), 64'd0);
    checkOutput("both_un", 64'(trap_underflow), 64'd0);
    wim = '0;

    // Move to window 1 and fill all of its visible windowed registers.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge Clk);
    #1;
    checkOutput("win1_cwp", 64'(cwp), 64'd1);
    for (int r = 8; r < 32; r++) begin
      applyStimulus(1'b1, 1'b1, 5'(r), 32'(100 + r), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge Clk);
    end

    // Clear window 1, trying a write and a save while busy.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge Clk);
    driveIdle();
    #1;
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 40) begin
      busy_cycles++;
      if (busy_cycles == 3)
        applyStimulus(1'b1, 1'b1, 5'd9, 32'hffff_ffff, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      else
        driveIdle();
      @(negedge Clk);
      #1;
    end
    checkOutput("clear_busy_cycles", 64'(busy_cycles), 64'd16);
    checkOutput("clear_done_high", 64'(wclr_done), 64'd1);
    checkOutput("clear_cwp_hold", 64'(cwp), 64'd1);
    @(negedge Clk);
    #1;
    checkOutput("clear_done_pulse", 64'(wclr_done), 64'd0);
    checkOutput("clear_busy_low", 64'(busy), 64'd0);
    for (int r = 8; r < 32; r++) begin
      readCheck($sformatf("clear_r%0d", r), 5'(r), (r < 24) ? 32'd0 : 32'(100 + r));
    end

    // Reset in the 5th cycle of a clear.
    applyStimulus(1'b1, 1'b1, 5'd3, 32'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge Clk);
    driveIdle();
    repeat (4) @(negedge Clk);
    #1;
    checkOutput("midclr_busy_before", 64'(busy), 64'd1);
    Clr = 1'b0;
    PA_in = 5'd3;
    PB_in = 5'd24;
    #1;
    checkOutput("midclr_busy", 64'(busy), 64'd0);
    checkOutput("midclr_done", 64'(wclr_done), 64'd0);
    checkOutput("midclr_cwp", 64'(cwp), 64'd0);
    checkOutput("midclr_read_g", 64'(PA_out), 64'd0);
    checkOutput("midclr_read_w", 64'(PB_out), 64'd0);
    @(negedge Clk);
    Clr = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'd4, 32'd77, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    driveIdle();
    PA_in = 5'd4;
    #1;
    checkOutput("post_reset_write", 64'(PA_out), 64'd77);
    checkOutput("post_reset_busy", 64'(busy), 64'd0);
    @(negedge Clk);
    #1;
    checkOutput("post_reset_idle", 64'(busy), 64'd0);
    checkOutput("post_reset_done", 64'(wclr_done), 64'd0);

    // Randomized run from a fresh reset against the model.
    Clr = 1'b0;
    #2;
    Clr = 1'b1;
    for (int i = 0; i < NP; i++) model[i] = '0;
    mcwp   = 0;
    exp_ov = 1'b0;
    exp_un = 1'b0;
    @(negedge Clk);
    for (int n = 0; n < 400; n++) begin
      checkOutput($sformatf("rnd%0d_cwp", n), 64'(cwp), 64'(mcwp));
      checkOutput($sformatf("rnd%0d_ov", n), 64'(trap_overflow), 64'(exp_ov));
      checkOutput($sformatf("rnd%0d_un", n), 64'(trap_underflow), 64'(exp_un));
      en_r  = 1'($urandom_range(0, 1));
      rw_r  = ($urandom_range(0, 3) != 0);
      pc_r  = 5'($urandom_range(0, 31));
      pa_r  = ($urandom_range(0, 3) == 0) ? pc_r : 5'($urandom_range(0, 31));
      pb_r  = 5'($urandom_range(0, 31));
      d_r   = $urandom;
      sv_r  = ($urandom_range(0, 5) == 0);
      rs_r  = ($urandom_range(0, 5) == 0);
      wim_r = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      wim   = wim_r;
      applyStimulus(en_r, rw_r, pc_r, d_r, pa_r, pb_r, sv_r, rs_r, 1'b0);
      ea = model[phys(pa_r, mcwp)];
      eb = model[phys(pb_r, mcwp)];
      if (en_r && rw_r && pc_r != 0) begin
        if (phys(pa_r, mcwp) == phys(pc_r, mcwp)) ea = d_r;
        if (phys(pb_r, mcwp) == phys(pc_r, mcwp)) eb = d_r;
      end
      if (pa_r == 0) ea = '0;
      if (pb_r == 0) eb = '0;
      #1;
      checkOutput($sformatf("rnd%0d_a", n), 64'(PA_out), 64'(ea));
      checkOutput($sformatf("rnd%0d_b", n), 64'(PB_out), 64'(eb));
      if (en_r && rw_r && pc_r != 0) model[phys(pc_r, mcwp)] = d_r;
      exp_ov = 1'b0;
      exp_un = 1'b0;
      if (sv_r && !rs_r) begin
        tgt = (mcwp + NW - 1) % NW;
        if (wim_r[tgt]) exp_ov = 1'b1;
        else            mcwp = tgt;
      end else if (rs_r && !sv_r) begin
        tgt = (mcwp + 1) % NW;
        if (wim_r[tgt]) exp_un = 1'b1;
        else            mcwp = tgt;
      end
      @(negedge Clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/windowed_register_file.md
WINDOWED_REGISTER_FILE -- requirements
Module: windowed_register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every register.
REQ-002 SHALL have parameter NWINDOWS, default 4, legal 2..32, number of register windows.
REQ-003 SHALL hold 8 + 16*NWINDOWS physical registers (8 globals, 16 per window).
REQ-004 SHALL have port Clk  input  1  single clock, rising-edge.
REQ-005 SHALL have port Clr  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in  input  WIDTH  write data.
REQ-007 SHALL have ports PA_in, PB_in  input  5  logical read addresses, ports A/B.
REQ-008 SHALL have port PC_in  input  5  logical write address, port C.
REQ-009 SHALL have ports enable, rw  input  1 each  write occurs when both are 1.
REQ-010 SHALL have ports save, restore  input  1 each  window-change requests.
REQ-011 SHALL have port wim  input  NWINDOWS  window invalid mask.
REQ-012 SHALL have port wclr  input  1  start clear of the current window.
REQ-013 SHALL have ports PA_out, PB_out  output  WIDTH  read data.
REQ-014 SHALL have port cwp  output  $clog2(NWINDOWS)  current window pointer.
REQ-015 SHALL have ports trap_overflow, trap_underflow  output  1 each  one-cycle trap pulses.
REQ-016 SHALL have ports busy, wclr_done  output  1 each  clear-engine status.

Function
REQ-017 SHALL map r0-r7 to globals 0-7; SHALL map r8-r31 to physical 8 + ((r-8) + 16*cwp) mod (16*NWINDOWS), so ins (r24-r31) of window w equal outs (r8-r15) of window w+1 mod NWINDOWS.
REQ-018 SHALL return 0 for reads of r0; writes to r0 SHALL be discarded.
REQ-019 SHALL read combinationally; when a write is active to the same physical register, PA_out/PB_out SHALL show in (write bypass).
REQ-020 SHALL write on the rising Clk edge when enable=1, rw=1, busy=0.
REQ-021 save SHALL set cwp to (cwp-1) mod NWINDOWS on the next edge unless wim[(cwp-1) mod NWINDOWS]=1, in which case cwp SHALL hold and trap_overflow SHALL pulse for one cycle.
REQ-022 restore SHALL set cwp to (cwp+1) mod NWINDOWS unless wim[(cwp+1) mod NWINDOWS]=1, in which case cwp SHALL hold and trap_underflow SHALL pulse for one cycle.
REQ-023 save and restore asserted together SHALL be ignored, with no trap.
REQ-024 a write in the same cycle as a save/restore SHALL use the pre-change cwp.
REQ-025 clear engine SHALL have states IDLE, CLEAR, DONE; wclr in IDLE SHALL go to CLEAR, latch cwp, and raise busy on the next edge.
REQ-026 CLEAR SHALL zero r8-r23 of the latched window, one register per cycle, for 16 cycles, then go to DONE.
REQ-027 DONE SHALL pulse wclr_done for one cycle, drop busy, and return to IDLE.
REQ-028 while busy=1, external writes, save, restore and wclr SHALL be ignored; reads SHALL remain functional.

Reset
REQ-029 Clr=0 SHALL immediately zero all registers, set cwp=0, state=IDLE, and set busy, wclr_done, trap_overflow and trap_underflow to 0, including in the middle of a clear.
REQ-030 after Clr deasserts, the first write SHALL be accepted on the first rising edge.

Structure
REQ-031 package windowed_register_file_pkg SHALL hold the region constants (NGLOBALS=8, WINDOW_REGS=16), the clear-state enum, and the default WIDTH/NWINDOWS.
REQ-032 sub-module window_addr_map SHALL convert (logical address, cwp) to the physical index and SHALL be instantiated for ports A, B, C and the clear engine.

Verification
REQ-033 write r1=11 and r9=22 at cwp=0; perform save -> cwp=3; read r1=11, read r25=22 (ins alias old outs).
REQ-034 wim=4'b1000 at cwp=0, pulse save -> trap_overflow high for exactly 1 cycle, cwp stays 0.
REQ-035 write r5=7, read PA_in=5 in the same cycle -> PA_out=7; write r0=9 -> PA_out=0 for r0.
REQ-036 fill r8-r31 of window 1, pulse wclr -> busy for 16 cycles, then wclr_done=1 for 1 cycle; r8-r23=0, r24-r31 unchanged.
REQ-037 assert Clr=0 at the 5th cycle of CLEAR -> busy=0 and all reads=0 immediately; after release, state is IDLE.
REQ-038 pulse save and restore together -> cwp unchanged and both trap outputs stay 0.
